rfe_enroll_ctrl: RTL
====================

Name: rfe_enroll_ctrl

Overview:
Enrollment sequencer for the device-side fuzzy-extractor generator. On a host start request it issues a single-cycle enable to the generator and waits for the generator's complete pulse, with a timeout. It then captures the generator's wide helper-data bus into a shadow buffer and streams it out as OUT_W-bit words over a valid/ready link toward helper-data storage (NVM writer). rprime never enters this block; only public helper data is streamed.

Parameters:
BLOCKS, 22, number of RM(1,5) blocks in helper data
N, 32, bits per block (helper bus width = BLOCKS*N)
OUT_W, 32, width of streamed helper-data word
TIMEOUT_CYCLES, 4096, max cycles to wait for gen_complete after enable (>=2)
WORDS (derived), ceil(BLOCKS*N/OUT_W), number of streamed words

Ports:
clk  in  1  system clock, single clock domain
rst_n  in  1  asynchronous active-low reset
start  in  1  host request; level sampled, accepted only in IDLE
abort  in  1  host abort; any non-IDLE state returns to IDLE
busy  out  1  high whenever state != IDLE
done  out  1  one-cycle pulse after last word handshake
error  out  1  sticky; set on timeout or abort, cleared when next start is accepted
gen_enable  out  1  enable to generator, registered, high exactly one cycle per run
gen_complete  in  1  generator complete pulse
gen_helper_data  in  BLOCKS*N  generator helper data, valid in cycle gen_complete is high
hd_valid  out  1  stream word valid
hd_ready  in  1  downstream ready
hd_data  out  OUT_W  current word = buffer[idx*OUT_W +: OUT_W], upper bits of final word zero-padded
hd_last  out  1  high with hd_valid when idx == WORDS-1
hd_index  out  max(1,$clog2(WORDS))  current word index

Behaviour:
- Reset: state IDLE. busy, done, error, gen_enable, hd_valid, hd_last = 0. hd_data, hd_index, shadow buffer, and timeout counter = 0.
- States: IDLE, ARM, WAIT, STREAM, DONE.
- IDLE: start=1 at edge E0 -> ARM. error cleared at E0. gen_enable is high E0..E1. The generator edge-detects, so gen_enable is low in IDLE and low from E1 onward.
- ARM: one cycle; clears the counter; -> WAIT unconditionally.
- WAIT: counter increments every cycle.
  - gen_complete=1 -> latch gen_helper_data into buffer that same edge, idx=0, -> STREAM.
  - Counter == TIMEOUT_CYCLES-1 with no complete -> error=1, -> IDLE.
  - gen_complete and timeout in the same cycle: complete wins, no error.
- STREAM: hd_valid=1 from the first cycle after capture. hd_data/hd_last/hd_index are combinational from idx and buffer.
  - Handshake = hd_valid & hd_ready. Each handshake increments idx.
  - hd_data must stay stable while hd_valid=1 and hd_ready=0.
  - Handshake with idx == WORDS-1 -> hd_valid=0 next cycle, -> DONE.
- DONE: done=1 for one cycle; -> IDLE. busy is still 1 in DONE.
- gen_complete outside WAIT is ignored; the buffer is unchanged.
- start outside IDLE is ignored and not queued. start held high after DONE starts a new run once IDLE is re-entered.
- abort=1 in ARM/WAIT/STREAM/DONE -> IDLE next edge, error=1, hd_valid=0. If abort coincides with the final handshake, abort wins: no done, error=1. abort in IDLE has no effect.
- If WORDS*OUT_W > BLOCKS*N, the unused top bits of the final word read 0.
- Asynchronous reset mid-run returns to the reset state immediately. No partial stream is resumed.

Test Plan:
- Nominal run (BLOCKS=22, N=32, OUT_W=32, hd_ready=1): start pulse -> gen_enable high for 1 cycle. Complete after 50 cycles -> 22 consecutive words equal to the helper-bus slices, hd_last on word 21, done pulse 1 cycle after the last handshake, error=0.
- Backpressure: hd_ready toggled 1,0,0,1 pattern -> hd_data/hd_index held during stalls. Exactly 22 handshakes in order, no duplicates, no skipped words.
- Timeout (TIMEOUT_CYCLES=64, no complete) -> error=1 and busy=0 after 64 WAIT cycles, no hd_valid. Next start clears error.
- Boundary: complete arrives exactly on counter 63 -> STREAM, error stays 0. Stray complete in IDLE and STREAM -> buffer and stream unchanged.
- Abort during STREAM at idx=5 -> hd_valid=0 next cycle, error=1, no done. Abort on the final handshake cycle -> no done.
- Padding (BLOCKS=3, N=32, OUT_W=64, WORDS=2) -> word1[63:32]=0. Async reset mid-WAIT -> all outputs at reset values.

Source files
------------

// File: rtl/rfe_enroll_ctrl_if.sv
// Helper-data stream link from the enrollment sequencer toward the NVM writer.
// Word valid/ready handshake, with the last-word flag and the word index alongside.
interface rfe_enroll_ctrl_if #(
  parameter int OUT_W = 32,
  parameter int IDX_W = 5
);
  logic             valid;
  logic             ready;
  logic [OUT_W-1:0] data;
  logic             last;
  logic [IDX_W-1:0] index;

  modport master (output valid, data, last, index, input ready);
  modport slave  (input valid, data, last, index, output ready);
endinterface

// File: rtl/rfe_enroll_ctrl.sv
// Enrollment sequencer: pulses the fuzzy-extractor generator, waits for completion with a timeout,
// captures the public helper data and streams it out word by word.
module rfe_enroll_ctrl #(
  parameter int BLOCKS         = 22,
  parameter int N              = 32,
  parameter int OUT_W          = 32,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_start,
  input  logic                  i_abort,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_error,
  output logic                  o_gen_enable,
  input  logic                  i_gen_complete,
  input  logic [BLOCKS*N-1:0]   i_gen_helper_data,
  rfe_enroll_ctrl_if.master     hd
);

  localparam int HD_W  = BLOCKS * N;
  localparam int WORDS = (HD_W + OUT_W - 1) / OUT_W;
  localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_WAIT,
    S_STREAM,
    S_DONE
  } state_t;

  state_t                 r_state;
  logic [HD_W-1:0]        r_buf;
  logic [IDX_W-1:0]       r_idx;
  logic [CNT_W-1:0]       r_cnt;
  logic                   r_busy;
  logic                   r_done;
  logic                   r_error;
  logic                   r_gen_enable;
  logic                   r_valid;

  logic                   w_hs;
  logic [WORDS*OUT_W-1:0] w_buf_pad;
  logic [OUT_W-1:0]       w_word;

  assign w_hs = r_valid & hd.ready;

  // NOTE: every register here uses <= so all branches see the pre-edge values of their neighbours.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      // NOTE: the shadow buffer is reset too, so hd_data reads zero after reset instead of stale helper data.
      r_buf        <= '0;
      r_idx        <= '0;
      r_cnt        <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_error      <= 1'b0;
      r_gen_enable <= 1'b0;
      r_valid      <= 1'b0;
    end else begin
      r_done       <= 1'b0;
      r_gen_enable <= 1'b0;
      if (r_state != S_IDLE && i_abort) begin
        // Abort outranks every in-flight event, including the final handshake.
        r_state <= S_IDLE;
        r_busy  <= 1'b0;
        r_error <= 1'b1;
        r_valid <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (i_start) begin
              r_state      <= S_ARM;
              r_busy       <= 1'b1;
              r_error      <= 1'b0;
              r_gen_enable <= 1'b1;
            end
          end
          S_ARM: begin
            r_cnt   <= '0;
            r_state <= S_WAIT;
          end
          S_WAIT: begin
            if (i_gen_complete) begin
              r_buf   <= i_gen_helper_data;
              r_idx   <= '0;
              r_valid <= 1'b1;
              r_state <= S_STREAM;
            end else if (r_cnt == CNT_MAX) begin
              r_error <= 1'b1;
              r_busy  <= 1'b0;
              r_state <= S_IDLE;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
          S_STREAM: begin
            if (w_hs) begin
              if (r_idx == LAST_IDX) begin
                r_valid <= 1'b0;
                r_done  <= 1'b1;
                r_state <= S_DONE;
              end else begin
                r_idx <= r_idx + 1'b1;
              end
            end
          end
          S_DONE: begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
          default: begin
            r_busy  <= 1'b0;
            r_valid <= 1'b0;
            r_state <= S_IDLE;
          end
        endcase
      end
    end
  end

  // NOTE: defaults first so no path through this block leaves a variable unassigned (no latches).
  always_comb begin
    w_buf_pad             = '0;
    w_buf_pad[HD_W-1:0]   = r_buf;
    w_word                = '0;
    for (int w = 0; w < WORDS; w++) begin
      if (r_idx == IDX_W'(w)) w_word = w_buf_pad[w*OUT_W +: OUT_W];
    end
  end

  assign hd.valid     = r_valid;
  assign hd.data      = w_word;
  assign hd.last      = r_valid && (r_idx == LAST_IDX);
  assign hd.index     = r_idx;

  assign o_busy       = r_busy;
  assign o_done       = r_done;
  assign o_error      = r_error;
  assign o_gen_enable = r_gen_enable;

endmodule
